// File: rtl/fpnew_dotp_result_buffer.sv
// ----------------------------------------------------------------------------
// fpnew_dotp_result_buffer
//
// Output stage behind the dot-product wrapper. Each accepted result is
// NaN-boxed to the full Width according to its destination format. It is then
// queued in a small FIFO, so the dot-product pipeline does not stall when the
// writeback port is slow. Exception flags of popped entries are accumulated
// into a sticky register.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   in_result_i..in_aux_i    upstream payload (result, status, ext bit,
//                            destination format, tag, aux)
//   in_valid_i / in_ready_o  upstream handshake (ready = not full)
//   flush_i                  synchronous flush, discards every entry
//   out_result_o..out_aux_o  head entry payload (result already NaN-boxed)
//   out_valid_o / out_ready_i downstream handshake
//   fflags_o / fflags_clr_i  sticky OR of popped status, and its clear
//   count_o, busy_o          occupancy, and occupancy != 0
// ----------------------------------------------------------------------------
module fpnew_dotp_result_buffer #(
    parameter int unsigned Width   = 64,
    parameter int unsigned Depth   = 2,
    parameter type         TagType = logic,
    parameter type         AuxType = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic [Width-1:0]           in_result_i,
    input  logic [4:0]                 in_status_i,
    input  logic                       in_ext_bit_i,
    input  logic [2:0]                 in_dst_fmt_i,
    input  TagType                     in_tag_i,
    input  AuxType                     in_aux_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic                       flush_i,
    output logic [Width-1:0]           out_result_o,
    output logic [4:0]                 out_status_o,
    output logic                       out_ext_bit_o,
    output TagType                     out_tag_o,
    output AuxType                     out_aux_o,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [4:0]                 fflags_o,
    input  logic                       fflags_clr_i,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       busy_o
);

    localparam int unsigned CntW = $clog2(Depth + 1);
    // With Depth=1 a 0-bit pointer is not legal, so keep one bit that never moves.
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

    // Widths of the fp_format_e encodings: FP32, FP64, FP16, FP8, FP16ALT, FP8ALT.
    // Undefined encodings return Width, so the result passes through unboxed.
    function automatic int unsigned fp_width(input logic [2:0] fmt);
        case (fmt)
            3'd0:    return 32;
            3'd1:    return 64;
            3'd2:    return 16;
            3'd3:    return 8;
            3'd4:    return 16;
            3'd5:    return 8;
            default: return Width;
        endcase
    endfunction

    function automatic logic [Width-1:0] nan_box(input logic [Width-1:0] res,
                                                 input logic [2:0]       fmt);
        int unsigned      w;
        logic [Width-1:0] upper;
        w = fp_width(fmt);
        if (w >= Width) begin
            return res;
        end
        upper = {Width{1'b1}} << w;
        return upper | (res & ~upper);
    endfunction

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    logic [Width-1:0] r_result  [Depth];
    logic [4:0]       r_status  [Depth];
    logic             r_ext_bit [Depth];
    TagType           r_tag     [Depth];
    AuxType           r_aux     [Depth];

    logic [PtrW-1:0]  r_wr_ptr;
    logic [PtrW-1:0]  r_rd_ptr;
    logic [CntW-1:0]  r_count;
    logic [4:0]       r_fflags;

    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_push;
    logic             w_pop;
    logic [4:0]       w_fflags_next;

    assign w_in_ready  = (r_count != CntW'(Depth));
    assign w_out_valid = (r_count != '0);
    assign w_push      = in_valid_i && w_in_ready && !flush_i;
    assign w_pop       = w_out_valid && out_ready_i && !flush_i;

    // A clear in the same cycle as a pop keeps only the popped status.
    assign w_fflags_next = (fflags_clr_i ? 5'b0 : r_fflags)
                         | (w_pop ? r_status[r_rd_ptr] : 5'b0);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_fflags <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                r_result[i]  <= '0;
                r_status[i]  <= '0;
                r_ext_bit[i] <= 1'b0;
                r_tag[i]     <= '0;
                r_aux[i]     <= '0;
            end
        end else begin
            if (flush_i) begin
                // Storage is left as is; only the bookkeeping is emptied.
                r_count  <= '0;
                r_rd_ptr <= r_wr_ptr;
            end else begin
                if (w_push) begin
                    r_result[r_wr_ptr]  <= nan_box(in_result_i, in_dst_fmt_i);
                    r_status[r_wr_ptr]  <= in_status_i;
                    r_ext_bit[r_wr_ptr] <= in_ext_bit_i;
                    r_tag[r_wr_ptr]     <= in_tag_i;
                    r_aux[r_wr_ptr]     <= in_aux_i;
                    r_wr_ptr            <= ptr_inc(r_wr_ptr);
                end
                if (w_pop) begin
                    r_rd_ptr <= ptr_inc(r_rd_ptr);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (w_pop && !w_push) begin
                    r_count <= r_count - 1'b1;
                end
            end
            r_fflags <= w_fflags_next;
        end
    end

    assign in_ready_o    = w_in_ready;
    assign out_valid_o   = w_out_valid;
    assign out_result_o  = r_result[r_rd_ptr];
    assign out_status_o  = r_status[r_rd_ptr];
    assign out_ext_bit_o = r_ext_bit[r_rd_ptr];
    assign out_tag_o     = r_tag[r_rd_ptr];
    assign out_aux_o     = r_aux[r_rd_ptr];
    assign fflags_o      = r_fflags;
    assign count_o       = r_count;
    assign busy_o        = (r_count != '0);

endmodule

// File: tb/tb_fpnew_dotp_result_buffer.sv
module tb_fpnew_dotp_result_buffer;

    localparam int unsigned Width = 64;
    localparam int unsigned Depth = 2;
    localparam logic [2:0] FP32 = 3'd0;
    localparam logic [2:0] FP64 = 3'd1;
    localparam logic [2:0] FP16 = 3'd2;

    logic             clk_i;
    logic             rst_ni;
    logic [Width-1:0] in_result_i;
    logic [4:0]       in_status_i;
    logic             in_ext_bit_i;
    logic [2:0]       in_dst_fmt_i;
    logic [7:0]       in_tag_i;
    logic [3:0]       in_aux_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             flush_i;
    logic [Width-1:0] out_result_o;
    logic [4:0]       out_status_o;
    logic             out_ext_bit_o;
    logic [7:0]       out_tag_o;
    logic [3:0]       out_aux_o;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [4:0]       fflags_o;
    logic             fflags_clr_i;
    logic [1:0]       count_o;
    logic             busy_o;

    int n_pass  = 0;
    int n_total = 0;

    fpnew_dotp_result_buffer #(
        .Width   (Width),
        .Depth   (Depth),
        .TagType (logic [7:0]),
        .AuxType (logic [3:0])
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .in_result_i   (in_result_i),
        .in_status_i   (in_status_i),
        .in_ext_bit_i  (in_ext_bit_i),
        .in_dst_fmt_i  (in_dst_fmt_i),
        .in_tag_i      (in_tag_i),
        .in_aux_i      (in_aux_i),
        .in_valid_i    (in_valid_i),
        .in_ready_o    (in_ready_o),
        .flush_i       (flush_i),
        .out_result_o  (out_result_o),
        .out_status_o  (out_status_o),
        .out_ext_bit_o (out_ext_bit_o),
        .out_tag_o     (out_tag_o),
        .out_aux_o     (out_aux_o),
        .out_valid_o   (out_valid_o),
        .out_ready_i   (out_ready_i),
        .fflags_o      (fflags_o),
        .fflags_clr_i  (fflags_clr_i),
        .count_o       (count_o),
        .busy_o        (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        in_result_i  = '0;
        in_status_i  = '0;
        in_ext_bit_i = 1'b0;
        in_dst_fmt_i = FP64;
        in_tag_i     = '0;
        in_aux_i     = '0;
        in_valid_i   = 1'b0;
        flush_i      = 1'b0;
        out_ready_i  = 1'b0;
        fflags_clr_i = 1'b0;
    endtask

    task automatic push_one(input logic [Width-1:0] res, input logic [2:0] fmt,
                            input logic [4:0] st, input logic [7:0] tag);
        in_result_i  = res;
        in_dst_fmt_i = fmt;
        in_status_i  = st;
        in_tag_i     = tag;
        in_valid_i   = 1'b1;
        tick();
        in_valid_i   = 1'b0;
    endtask

    task automatic pop_one();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if (out_valid_o !== 1'b0 || count_o !== 2'd0 || busy_o !== 1'b0
            || fflags_o !== 5'd0 || out_result_o !== 64'd0 || in_ready_o !== 1'b1)
            $display("FAIL reset_state: valid=%b count=%0d busy=%b fflags=%b result=%h ready=%b, want 0 0 0 00000 0 1",
                     out_valid_o, count_o, busy_o, fflags_o, out_result_o, in_ready_o);
        else n_pass++;
    endtask

    task automatic test_single_push();
        push_one(64'h0000_0000_3F80_0000, FP32, 5'b00001, 8'h11);
        n_total++;
        if (out_valid_o !== 1'b1 || out_result_o !== 64'hFFFF_FFFF_3F80_0000 || count_o !== 2'd1)
            $display("FAIL single_push: valid=%b result=%h count=%0d, want 1 ffffffff3f800000 1",
                     out_valid_o, out_result_o, count_o);
        else n_pass++;
        n_total++;
        if (out_tag_o !== 8'h11 || out_status_o !== 5'b00001 || busy_o !== 1'b1)
            $display("FAIL single_head: tag=%h status=%b busy=%b, want 11 00001 1",
                     out_tag_o, out_status_o, busy_o);
        else n_pass++;
        pop_one();
        n_total++;
        if (fflags_o !== 5'b00001 || count_o !== 2'd0 || out_valid_o !== 1'b0)
            $display("FAIL single_pop: fflags=%b count=%0d valid=%b, want 00001 0 0",
                     fflags_o, count_o, out_valid_o);
        else n_pass++;
    endtask

    task automatic test_fill();
        push_one(64'h0000_0000_0000_3C00, FP16, 5'b00000, 8'h21);
        push_one(64'h3FF0_0000_0000_0000, FP64, 5'b00000, 8'h22);
        n_total++;
        if (in_ready_o !== 1'b0 || count_o !== 2'd2)
            $display("FAIL fill_full: ready=%b count=%0d, want 0 2", in_ready_o, count_o);
        else n_pass++;
        n_total++;
        if (out_result_o !== 64'hFFFF_FFFF_FFFF_3C00 || out_tag_o !== 8'h21)
            $display("FAIL fill_head0: result=%h tag=%h, want ffffffffffff3c00 21", out_result_o, out_tag_o);
        else n_pass++;
        pop_one();
        n_total++;
        if (out_result_o !== 64'h3FF0_0000_0000_0000 || out_tag_o !== 8'h22 || count_o !== 2'd1)
            $display("FAIL fill_head1: result=%h tag=%h count=%0d, want 3ff0000000000000 22 1",
                     out_result_o, out_tag_o, count_o);
        else n_pass++;
        pop_one();
        n_total++;
        if (count_o !== 2'd0 || fflags_o !== 5'b00001)
            $display("FAIL fill_drain: count=%0d fflags=%b, want 0 00001", count_o, fflags_o);
        else n_pass++;
    endtask

    task automatic test_streaming();
        int errs = 0;
        in_valid_i   = 1'b1;
        out_ready_i  = 1'b1;
        in_dst_fmt_i = FP64;
        in_status_i  = '0;
        for (int i = 0; i < 10; i++) begin
            in_tag_i    = 8'(i);
            in_result_i = 64'(i) + 64'h100;
            if (in_ready_o !== 1'b1) errs++;
            tick();
            if (out_valid_o !== 1'b1 || count_o !== 2'd1 || out_tag_o !== 8'(i)
                || out_result_o !== 64'(i) + 64'h100) begin
                errs++;
                $display("FAIL stream_cycle%0d: valid=%b count=%0d tag=%0d result=%h, want 1 1 %0d %h",
                         i, out_valid_o, count_o, out_tag_o, out_result_o, i, 64'(i) + 64'h100);
            end
        end
        in_valid_i = 1'b0;
        tick();
        out_ready_i = 1'b0;
        n_total++;
        if (errs != 0)
            $display("FAIL stream_order: %0d bad cycles, want 0", errs);
        else n_pass++;
        n_total++;
        if (count_o !== 2'd0 || out_valid_o !== 1'b0)
            $display("FAIL stream_drain: count=%0d valid=%b, want 0 0", count_o, out_valid_o);
        else n_pass++;
    endtask

    task automatic test_flush();
        push_one(64'h1, FP64, 5'b10000, 8'hA1);
        push_one(64'h2, FP64, 5'b10000, 8'hA2);
        in_result_i = 64'h3;
        in_tag_i    = 8'hEE;
        in_status_i = 5'b01000;
        in_valid_i  = 1'b1;
        out_ready_i = 1'b1;
        flush_i     = 1'b1;
        tick();
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        n_total++;
        if (count_o !== 2'd0 || out_valid_o !== 1'b0 || fflags_o !== 5'b00001 || in_ready_o !== 1'b1)
            $display("FAIL flush_state: count=%0d valid=%b fflags=%b ready=%b, want 0 0 00001 1",
                     count_o, out_valid_o, fflags_o, in_ready_o);
        else n_pass++;
        out_ready_i = 1'b1;
        tick();
        tick();
        out_ready_i = 1'b0;
        n_total++;
        if (count_o !== 2'd0 || out_valid_o !== 1'b0 || fflags_o !== 5'b00001)
            $display("FAIL flush_no_ghost: count=%0d valid=%b fflags=%b, want 0 0 00001",
                     count_o, out_valid_o, fflags_o);
        else n_pass++;
        // After a flush the next push must appear normally at the head.
        push_one(64'h4, FP64, 5'b00000, 8'h44);
        n_total++;
        if (out_tag_o !== 8'h44 || count_o !== 2'd1)
            $display("FAIL flush_recover: tag=%h count=%0d, want 44 1", out_tag_o, count_o);
        else n_pass++;
        pop_one();
    endtask

    task automatic test_sticky();
        fflags_clr_i = 1'b1;
        tick();
        fflags_clr_i = 1'b0;
        n_total++;
        if (fflags_o !== 5'b00000)
            $display("FAIL sticky_clear: fflags=%b, want 00000", fflags_o);
        else n_pass++;
        push_one(64'h5, FP64, 5'b10000, 8'h51);
        push_one(64'h6, FP64, 5'b00100, 8'h52);
        pop_one();
        n_total++;
        if (fflags_o !== 5'b10000)
            $display("FAIL sticky_nv: fflags=%b, want 10000", fflags_o);
        else n_pass++;
        pop_one();
        n_total++;
        if (fflags_o !== 5'b10100)
            $display("FAIL sticky_nv_of: fflags=%b, want 10100", fflags_o);
        else n_pass++;
        push_one(64'h7, FP64, 5'b00010, 8'h53);
        fflags_clr_i = 1'b1;
        pop_one();
        fflags_clr_i = 1'b0;
        n_total++;
        if (fflags_o !== 5'b00010)
            $display("FAIL sticky_clr_pop: fflags=%b, want 00010", fflags_o);
        else n_pass++;
    endtask

    task automatic test_async_reset();
        push_one(64'h8, FP64, 5'b00001, 8'h61);
        push_one(64'h9, FP64, 5'b00001, 8'h62);
        n_total++;
        if (count_o !== 2'd2)
            $display("FAIL areset_precond: count=%0d, want 2", count_o);
        else n_pass++;
        out_ready_i = 1'b1;
        #2 rst_ni = 1'b0;
        #1;
        n_total++;
        if (out_valid_o !== 1'b0 || busy_o !== 1'b0 || fflags_o !== 5'd0
            || count_o !== 2'd0 || out_result_o !== 64'd0)
            $display("FAIL areset_immediate: valid=%b busy=%b fflags=%b count=%0d result=%h, want 0 0 00000 0 0",
                     out_valid_o, busy_o, fflags_o, count_o, out_result_o);
        else n_pass++;
        tick();
        out_ready_i = 1'b0;
        rst_ni = 1'b1;
        tick();
        n_total++;
        if (out_valid_o !== 1'b0 || fflags_o !== 5'd0)
            $display("FAIL areset_no_residual: valid=%b fflags=%b, want 0 00000", out_valid_o, fflags_o);
        else n_pass++;
        test_single_push();
    endtask

    initial begin
        idle_inputs();
        rst_ni = 1'b0;
        #23;
        test_reset();
        rst_ni = 1'b1;
        tick();
        test_reset();
        test_single_push();
        test_fill();
        test_streaming();
        test_flush();
        test_sticky();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, want finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
